// File: rtl/systola_pkg.sv
// systola_pkg: shared types for the systolic-array front end.
//   tile_loader_state_t : tile_loader FSM states
//   DEFAULT_DW / elem_t : default element width and element type
package systola_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} tile_loader_state_t;
    localparam int DEFAULT_DW = 8;
    typedef logic [DEFAULT_DW-1:0] elem_t;
endpackage

// File: rtl/tile_loader_lane_onehot.sv
// lane_onehot: registers a lane index plus enable as a one-hot write strobe.
//   clk, rstn : clock, synchronous active-low reset
//   en        : produce a strobe next cycle
//   lane      : lane index to strobe
//   onehot    : registered one-hot strobe (all zero when en was low)
module lane_onehot
    import systola_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [LW-1:0]    lane,
    output logic [LANES-1:0] onehot
);
    logic [LANES-1:0] onehot_d, onehot_q;

    always_comb onehot_d = en ? (LANES'(1) << lane) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) onehot_q <= '0;
        else       onehot_q <= onehot_d;
    end

    assign onehot = onehot_q;
endmodule

// File: rtl/tile_loader.sv
// tile_loader: streams one tile round-robin into LANES input buffers, then bursts a common read.
//   clk, rstn  : clock, synchronous active-low reset
//   start      : begin a tile (IDLE only)
//   in_valid/in_ready/in_data : input element stream
//   buf_write  : registered one-hot lane write strobe
//   buf_din    : registered shared write data
//   buf_read   : common read strobe, DEPTH+LANES-1 cycles
//   busy, done : FSM not idle / one-cycle completion pulse
// Optional macro TILE_LOADER_AUTOSTART_EN: in_valid also leaves IDLE.
module tile_loader
    import systola_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 8,
    parameter int DW    = DEFAULT_DW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic [LANES-1:0] buf_write,
    output logic [DW-1:0]    buf_din,
    output logic             buf_read,
    output logic             busy,
    output logic             done
);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int EW    = $clog2(LANES * DEPTH + 1);
    localparam int CW    = $clog2(DEPTH + LANES);
    localparam int TOTAL = LANES * DEPTH;
    localparam int RLEN  = DEPTH + LANES - 1;

    tile_loader_state_t state_d, state_q;
    logic [LW-1:0] lane_cnt_d, lane_cnt_q;
    logic [EW-1:0] elem_cnt_d, elem_cnt_q;
    logic [CW-1:0] drain_cnt_d, drain_cnt_q;
    logic          in_ready_d, in_ready_q;
    logic [DW-1:0] buf_din_d, buf_din_q;
    logic          accept, go;

    assign accept = in_valid && in_ready_q;

`ifdef TILE_LOADER_AUTOSTART_EN
    assign go = start || in_valid;
`else
    assign go = start;
`endif

    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        elem_cnt_d  = elem_cnt_q;
        drain_cnt_d = drain_cnt_q;
        buf_din_d   = accept ? in_data : buf_din_q;
        case (state_q)
            IDLE: if (go) begin
                state_d     = LOAD;
                lane_cnt_d  = '0;
                elem_cnt_d  = '0;
                drain_cnt_d = '0;
            end
            LOAD: if (accept) begin
                lane_cnt_d = (lane_cnt_q == LW'(LANES - 1)) ? '0 : lane_cnt_q + 1'b1;
                elem_cnt_d = elem_cnt_q + 1'b1;
                if (elem_cnt_q == EW'(TOTAL - 1)) state_d = DRAIN;
            end
            // First DRAIN cycle carries the final write; reads occupy drain_cnt 1..RLEN.
            DRAIN: if (drain_cnt_q == CW'(RLEN)) state_d = DONE;
                   else drain_cnt_d = drain_cnt_q + 1'b1;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lane_cnt_q  <= '0;
            elem_cnt_q  <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            buf_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            elem_cnt_q  <= elem_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            buf_din_q   <= buf_din_d;
        end
    end

    lane_onehot #(.LANES(LANES), .LW(LW)) u_onehot (
        .clk    (clk),
        .rstn   (rstn),
        .en     (accept),
        .lane   (lane_cnt_q),
        .onehot (buf_write)
    );

    assign in_ready = in_ready_q;
    assign buf_din  = buf_din_q;
    assign buf_read = (state_q == DRAIN) && (drain_cnt_q != '0);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: scenario table plus scoreboard of lane writes for tile_loader (LANES=3, DEPTH=4).
module tb_tile_loader;
    logic       clk = 0;
    logic       rstn = 0;
    logic       start = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in_data = 0;
    logic [2:0] buf_write;
    logic [7:0] buf_din;
    logic       buf_read;
    logic       busy;
    logic       done;

    tile_loader #(.LANES(3), .DEPTH(4), .DW(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .buf_write(buf_write), .buf_din(buf_din), .buf_read(buf_read),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int lane; logic [7:0] data; } wr_t;
    typedef struct { bit use_start; bit bubble; bit spur; logic [7:0] base; int exp_len; } scen_t;

    wr_t q[$];
    int  errors = 0, checks = 0;
    int  cyc = 0;
    int  wr_cnt, read_cnt, done_cnt, last_wr, first_rd, last_rd, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (buf_write != 0) begin
            wr_t e;
            wr_cnt++;
            last_wr = cyc;
            if (q.size() == 0) check("extra_write", {29'd0, buf_write}, 32'd0);
            else begin
                e = q.pop_front();
                check("write_lane", {29'd0, buf_write}, {29'd0, 3'd1 << e.lane});
                check("write_data", {24'd0, buf_din}, {24'd0, e.data});
            end
        end
        if (buf_read) begin
            if (read_cnt == 0) first_rd = cyc;
            last_rd = cyc;
            read_cnt++;
            check("read_write_overlap", {29'd0, buf_write}, 32'd0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", {31'd0, busy}, 32'd1);
        end
    end

    task automatic run_tile(input scen_t s, input string tag);
        int k = 0, t = 0, n = 0, c0;
        logic acc;
        wr_cnt = 0; read_cnt = 0; done_cnt = 0; first_rd = 0; last_wr = 0; last_rd = 0; done_cyc = 0;
        @(posedge clk); #1;
        c0 = cyc;
        if (s.use_start) start = 1;
        else begin in_valid = 1; in_data = s.base + 8'd1; end
        @(posedge clk); #1;
        start = 0;
        while (k < 12 && t < 100) begin
            t++;
            in_valid = s.bubble ? (t % 2 == 1) : 1'b1;
            in_data  = s.base + 8'(k) + 8'd1;
            start    = s.spur && (k == 5);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin q.push_back('{k % 3, s.base + 8'(k) + 8'd1}); k++; end
            #1;
        end
        check({tag, "_accepts"}, k, 12);
        in_valid = 1;
        in_data  = 8'hEE;
        start    = s.spur;
        @(negedge clk);
        check({tag, "_ready_low_after_last"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        start = 0;
        while (done_cnt == 0 && n < 60) begin @(posedge clk); n++; end
        #1;
        in_valid = 0;
        check({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_write_count"}, wr_cnt, 12);
        check({tag, "_read_count"}, read_cnt, 6);
        check({tag, "_read_contiguous"}, last_rd - first_rd, 5);
        check({tag, "_first_read_after_last_write"}, first_rd - last_wr, 1);
        check({tag, "_done_after_last_read"}, done_cyc - last_rd, 1);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_tile_time"}, done_cyc - c0, s.exp_len);
        check({tag, "_queue_empty"}, q.size(), 0);
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        scen_t tbl[3];
        tbl[0] = '{1, 0, 0, 8'h00, 20};
        tbl[1] = '{1, 1, 0, 8'h40, 31};
        tbl[2] = '{1, 0, 1, 8'h80, 20};

        // reset held two cycles with a valid element offered
        in_valid = 1; in_data = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_buf_write", {29'd0, buf_write}, 32'd0);
        check("rst_buf_din", {24'd0, buf_din}, 32'd0);
        check("rst_buf_read", {31'd0, buf_read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
`ifdef TILE_LOADER_AUTOSTART_EN
        in_valid = 0;
        @(posedge clk); #1;
        rstn = 1;
`else
        @(posedge clk); #1;
        rstn = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_hold_busy", {31'd0, busy}, 32'd0);
            check("idle_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 0;
`endif

        for (int i = 0; i < 3; i++) run_tile(tbl[i], $sformatf("scen%0d", i));

        // reset after 7 accepts, then restart with 0x20..0x2B
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        in_valid = 1;
        for (int k = 0; k < 7; k++) begin
            in_data = 8'h10 + 8'(k);
            q.push_back('{k % 3, 8'h10 + 8'(k)});
            @(posedge clk); #1;
        end
        in_valid = 0;
        rstn = 0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_buf_write", {29'd0, buf_write}, 32'd0);
        check("midrst_buf_din", {24'd0, buf_din}, 32'd0);
        check("midrst_buf_read", {31'd0, buf_read}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_pending", q.size(), 0);
        q.delete();
        @(posedge clk); #1;
        rstn = 1;
        run_tile('{1, 0, 0, 8'h1F, 20}, "restart");

`ifdef TILE_LOADER_AUTOSTART_EN
        run_tile('{0, 0, 0, 8'h00, 20}, "autostart");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
